// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle MIPS controller.
// MC_BNE_EN adds bne (op 000101) as a legal branch opcode.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // ALU operation class handed from the FSM to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PC_ALURES = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_aludec.sv
// Maps the FSM's ALU operation class (and funct for R-type) to an ALU control code.
module mc_aludec
    import mc_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [3:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                // Unknown funct codes quietly fall back to ADD
                case (funct)
                    F_ADD:   alucontrol = ALU_ADD;
                    F_SUB:   alucontrol = ALU_SUB;
                    F_AND:   alucontrol = ALU_AND;
                    F_OR:    alucontrol = ALU_OR;
                    F_SLT:   alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS sequencer: Moore FSM driving the shared-memory/shared-ALU datapath.
// Optional MC_BNE_EN: bne goes through BRANCH with an inverted zero test.
module mc_controller
    import mc_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       pcen,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [3:0] alucontrol,
    output logic       illegal
);

    state_t     state_reg;
    state_t     state_next;
    logic       pcwrite;
    logic       branch;
    logic       branch_taken;
    logic [1:0] aluop;

`ifdef MC_BNE_EN
    logic bne_reg;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= state_t'(RESET_STATE);
`ifdef MC_BNE_EN
            bne_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
`ifdef MC_BNE_EN
            // Remember which branch flavour was decoded; op is not re-examined in BRANCH
            if (state_reg == DECODE)
                bne_reg <= (op == OP_BNE);
`endif
        end
    end

`ifdef MC_BNE_EN
    assign branch_taken = bne_reg ? ~zero : zero;
`else
    assign branch_taken = zero;
`endif

    always_comb begin
        state_next = FETCH;
        mem_req    = 1'b0;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_B;
        pcsrc      = PC_ALURES;
        aluop      = ALUOP_ADD;
        illegal    = 1'b0;

        case (state_reg)
            FETCH: begin
                mem_req = 1'b1;
                alusrcb = SRCB_FOUR;
                if (mem_ready) begin
                    irwrite    = 1'b1;
                    pcwrite    = 1'b1;
                    state_next = DECODE;
                end else begin
                    state_next = FETCH;
                end
            end
            DECODE: begin
                alusrcb = SRCB_IMMSH;
                case (op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = EXECUTE;
                    OP_BEQ:       state_next = BRANCH;
`ifdef MC_BNE_EN
                    OP_BNE:       state_next = BRANCH;
`endif
                    OP_ADDI:      state_next = ADDIEX;
                    OP_J:         state_next = JUMP;
                    default: begin
                        illegal    = 1'b1;
                        state_next = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                if (op == OP_LW)
                    state_next = MEMRD;
                else if (op == OP_SW)
                    state_next = MEMWR;
                else
                    state_next = FETCH;
            end
            MEMRD: begin
                mem_req    = 1'b1;
                iord       = 1'b1;
                state_next = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            MEMWR: begin
                mem_req    = 1'b1;
                iord       = 1'b1;
                memwrite   = 1'b1;
                state_next = mem_ready ? FETCH : MEMWR;
            end
            EXECUTE: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_FUNCT;
                state_next = ALUWB;
            end
            ALUWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            BRANCH: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = PC_ALUOUT;
                branch  = 1'b1;
            end
            ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = SRCB_IMM;
                state_next = ADDIWB;
            end
            ADDIWB: begin
                regwrite = 1'b1;
            end
            JUMP: begin
                pcsrc   = PC_JUMP;
                pcwrite = 1'b1;
            end
            default: state_next = FETCH;
        endcase

        // While reset is held, present FETCH's static selects with every enable off
        if (!reset) begin
            mem_req  = 1'b0;
            iord     = 1'b0;
            memwrite = 1'b0;
            irwrite  = 1'b0;
            pcwrite  = 1'b0;
            branch   = 1'b0;
            regwrite = 1'b0;
            regdst   = 1'b0;
            memtoreg = 1'b0;
            alusrca  = 1'b0;
            alusrcb  = SRCB_FOUR;
            pcsrc    = PC_ALURES;
            aluop    = ALUOP_ADD;
            illegal  = 1'b0;
        end
    end

    assign pcen = pcwrite | (branch & branch_taken);

    mc_aludec u_aludec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_mc_controller.sv
// Randomized instruction-level bench: builds the expected per-cycle output trace of each instruction.
module tb_mc_controller;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcen;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [3:0] alucontrol;
    logic       illegal;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .iord       (iord),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .pcen       (pcen),
        .regwrite   (regwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MC_BNE_EN
    localparam bit BNE_EN = 1'b1;
`else
    localparam bit BNE_EN = 1'b0;
`endif

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000, JMP = 6'b000010;
    localparam logic [3:0] A_ADD = 4'b0010, A_SUB = 4'b0110;

    // Vector layout: mem_req iord memwrite irwrite pcen regwrite regdst memtoreg alusrca alusrcb pcsrc alucontrol illegal
    localparam logic [17:0] M_EN   = {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b1};
    localparam logic [17:0] M_IORD = 18'd1 << 16;
    localparam logic [17:0] M_RD   = 18'd1 << 11;
    localparam logic [17:0] M_MT   = 18'd1 << 10;
    localparam logic [17:0] M_ASA  = 18'd1 << 9;
    localparam logic [17:0] M_ASB  = 18'd3 << 7;
    localparam logic [17:0] M_PCS  = 18'd3 << 5;
    localparam logic [17:0] M_ALU  = 18'd15 << 1;

    typedef struct {
        logic [17:0] exp;
        logic [17:0] mask;
        logic        mr;
        logic        z;
        logic [5:0]  op;
        logic [5:0]  funct;
        string       tag;
    } cyc_t;

    cyc_t       q[$];
    logic [5:0] cur_op;
    logic [5:0] cur_funct;
    int         n_checks = 0;
    int         n_pass   = 0;

    function automatic logic [17:0] vec(input logic rq, input logic io, input logic mw, input logic ir,
                                        input logic pe, input logic rw, input logic rd, input logic mt,
                                        input logic asa, input logic [1:0] asb, input logic [1:0] pcs,
                                        input logic [3:0] alu, input logic il);
        return {rq, io, mw, ir, pe, rw, rd, mt, asa, asb, pcs, alu, il};
    endfunction

    function automatic logic [17:0] observed();
        return {mem_req, iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg,
                alusrca, alusrcb, pcsrc, alucontrol, illegal};
    endfunction

    function automatic bit legal_op(input logic [5:0] o);
        if (o == LW || o == SW || o == RT || o == BEQ || o == ADDI || o == JMP) return 1'b1;
        if (o == BNE) return BNE_EN;
        return 1'b0;
    endfunction

    function automatic logic [3:0] alu_for(input logic [5:0] f);
        case (f)
            6'b100000: return 4'b0010;
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            default:   return 4'b0010;
        endcase
    endfunction

    task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %05h expected %05h at %0t", tag, got, exp, $time);
    endtask

    task automatic add(input string tag, input logic [17:0] e, input logic [17:0] m,
                       input logic mr, input logic z);
        cyc_t c;
        c.exp = e; c.mask = m; c.mr = mr; c.z = z;
        c.op = cur_op; c.funct = cur_funct; c.tag = tag;
        q.push_back(c);
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected trace of one instruction, from the per-state rules and wait counts
    task automatic push_insn(input logic [5:0] o, input logic [5:0] f, input int wf, input int wm, input logic zb);
        logic tk;
        cur_op = o; cur_funct = f;
        for (int i = 0; i < wf; i++)
            add("fetch_wait", vec(1,0,0,0,0,0,0,0,0,2'b01,2'b00,A_ADD,0), M_EN|M_IORD|M_ASA|M_ASB|M_PCS|M_ALU, 1'b0, rbit());
        add("fetch", vec(1,0,0,1,1,0,0,0,0,2'b01,2'b00,A_ADD,0), M_EN|M_IORD|M_ASA|M_ASB|M_PCS|M_ALU, 1'b1, rbit());
        add("decode", vec(0,0,0,0,0,0,0,0,0,2'b11,2'b00,A_ADD,!legal_op(o)), M_EN|M_ASA|M_ASB|M_ALU, rbit(), rbit());
        if (!legal_op(o)) return;
        if (o == LW || o == SW) begin
            add("memadr", vec(0,0,0,0,0,0,0,0,1,2'b10,2'b00,A_ADD,0), M_EN|M_ASA|M_ASB|M_ALU, rbit(), rbit());
            for (int i = 0; i <= wm; i++)
                add(o == LW ? "memrd" : "memwr", vec(1,1,(o == SW),0,0,0,0,0,0,2'b00,2'b00,4'h0,0),
                    M_EN|M_IORD, (i == wm), rbit());
            if (o == LW)
                add("memwb", vec(0,0,0,0,0,1,0,1,0,2'b00,2'b00,4'h0,0), M_EN|M_RD|M_MT, rbit(), rbit());
        end else if (o == RT) begin
            add("execute", vec(0,0,0,0,0,0,0,0,1,2'b00,2'b00,alu_for(f),0), M_EN|M_ASA|M_ASB|M_ALU, rbit(), rbit());
            add("aluwb", vec(0,0,0,0,0,1,1,0,0,2'b00,2'b00,4'h0,0), M_EN|M_RD|M_MT, rbit(), rbit());
        end else if (o == BEQ || o == BNE) begin
            tk = (o == BNE) ? ~zb : zb;
            add("branch", vec(0,0,0,0,tk,0,0,0,1,2'b00,2'b01,A_SUB,0), M_EN|M_ASA|M_ASB|M_ALU|M_PCS, rbit(), zb);
        end else if (o == ADDI) begin
            add("addiex", vec(0,0,0,0,0,0,0,0,1,2'b10,2'b00,A_ADD,0), M_EN|M_ASA|M_ASB|M_ALU, rbit(), rbit());
            add("addiwb", vec(0,0,0,0,0,1,0,0,0,2'b00,2'b00,4'h0,0), M_EN|M_RD|M_MT, rbit(), rbit());
        end else begin
            add("jump", vec(0,0,0,0,1,0,0,0,0,2'b00,2'b10,4'h0,0), M_EN|M_PCS, rbit(), rbit());
        end
    endtask

    task automatic run_n(input int n);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c = q.pop_front();
            @(posedge clk);
            #1;
            op = c.op; funct = c.funct; mem_ready = c.mr; zero = c.z;
            #3;
            check(c.tag, observed() & c.mask, c.exp & c.mask);
        end
    endtask

    task automatic do_insn(input int idx, input logic [5:0] o, input logic [5:0] f,
                           input int wf, input int wm, input logic zb);
        int n;
        push_insn(o, f, wf, wm, zb);
        n = q.size();
        run_n(n);
        $display("insn %0d op=%06b funct=%06b zero=%0b fetch_wait=%0d mem_wait=%0d cycles=%0d",
                 idx, o, f, zb, wf, wm, n);
    endtask

    localparam logic [17:0] RST_VEC = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 4'b0010, 1'b0};

    initial begin
        logic [5:0] ops[8];
        logic [5:0] ro;
        int k;
        ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = BEQ;
        ops[4] = ADDI; ops[5] = JMP; ops[6] = BNE; ops[7] = 6'b111111;

        reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
        #1 reset = 1'b0;
        #1 check("reset_outputs", observed(), RST_VEC);
        @(posedge clk); #1;
        check("reset_outputs_clk", observed(), RST_VEC);
        mem_ready = 1'b0;
        reset = 1'b1;
        #1 check("release_fetch", observed() & (M_EN|M_IORD), {1'b1, 17'd0});

        // Abort an lw while it waits in MEMRD, then restart cleanly
        push_insn(LW, 6'd0, 0, 4, 1'b0);
        run_n(5);
        q.delete();
        #1 reset = 1'b0; mem_ready = 1'b1;
        #1 check("reset_mid_memrd", observed(), RST_VEC);
        @(posedge clk); #1;
        check("reset_mid_memrd_clk", observed(), RST_VEC);
        mem_ready = 1'b0;
        reset = 1'b1;
        #1 check("restart_fetch", observed() & (M_EN|M_IORD), {1'b1, 17'd0});

        do_insn(0, LW, 6'd0, 0, 0, 1'b0);
        do_insn(1, SW, 6'd0, 1, 3, 1'b0);
        do_insn(2, RT, 6'b101010, 0, 0, 1'b0);
        do_insn(3, BEQ, 6'd0, 0, 0, 1'b1);
        do_insn(4, BEQ, 6'd0, 0, 0, 1'b0);
        do_insn(5, BNE, 6'd0, 0, 0, 1'b0);
        do_insn(6, BNE, 6'd0, 0, 0, 1'b1);
        do_insn(7, 6'b111111, 6'd0, 0, 0, 1'b0);
        do_insn(8, ADDI, 6'd0, 2, 0, 1'b0);
        do_insn(9, JMP, 6'd0, 0, 0, 1'b0);

        for (int i = 10; i < 90; i++) begin
            k = $urandom_range(0, 7);
            ro = ops[k];
            if (k == 7) begin
                ro = 6'($urandom_range(0, 63));
                while (legal_op(ro)) ro = 6'($urandom_range(0, 63));
            end
            do_insn(i, ro, 6'($urandom_range(0, 63)), $urandom_range(0, 3), $urandom_range(0, 3), rbit());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle sequencer for the MIPS datapath. One instruction executes over 3-5 states and shares a single memory port and a single ALU.
- Decodes opcode/funct and drives per-state enables and mux selects into the multicycle datapath.
- Waits on a memory ready handshake for every memory access.
- Sits beside the datapath inside the top-level mips wrapper, replacing the single-cycle combinational controller.

Parameters:
- RESET_STATE, 4'd0 (FETCH): state entered on reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- op  in  6  instr[31:26], taken from the instruction register.
- funct  in  6  instr[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completed the access this cycle.
- mem_req  out  1  memory access request.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memwrite  out  1  store strobe; valid only while mem_req=1.
- irwrite  out  1  load the instruction register.
- pcen  out  1  PC write enable = pcwrite | (branch & branch_taken).
- regwrite  out  1  register file write enable.
- regdst  out  1  write address select: 1 = rd, 0 = rt.
- memtoreg  out  1  write data select: 1 = MDR, 0 = ALUOut.
- alusrca  out  1  ALU A select: 0 = PC, 1 = A.
- alusrcb  out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- pcsrc  out  2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- alucontrol  out  4  ALU operation.
- illegal  out  1  one-cycle pulse on an undefined opcode.

Behaviour:
- Moore FSM with a 4-bit state register; all outputs are decoded from state (plus op/funct/zero where stated).
- Reset is asynchronous: state goes to FETCH immediately. During reset all outputs are 0, except alusrcb=01 and alucontrol=ADD, which are FETCH's static values. Releasing reset mid-instruction restarts at FETCH with no partial writes.
- States and per-state behaviour:
  - FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, alucontrol=ADD, pcsrc=00. Stays in FETCH while mem_ready=0 (all enables low). In the cycle mem_ready=1: irwrite=1 and pcwrite=1, then go to DECODE.
  - DECODE: alusrca=0, alusrcb=11, ADD (computes the branch target). Next state by op:
    - lw/sw (100011/101011) -> MEMADR
    - R-type (000000) -> EXECUTE
    - beq (000100) -> BRANCH
    - addi (001000) -> ADDIEX
    - j (000010) -> JUMP
    - anything else -> FETCH, with illegal=1 for one cycle.
  - MEMADR: alusrca=1, alusrcb=10, ADD. Go to MEMRD for lw, MEMWR for sw.
  - MEMRD: mem_req=1, iord=1. Stays until mem_ready, then go to MEMWB.
  - MEMWB: regwrite=1, regdst=0, memtoreg=1, then go to FETCH.
  - MEMWR: mem_req=1, iord=1, memwrite=1. Stays until mem_ready, then go to FETCH.
  - EXECUTE: alusrca=1, alusrcb=00, alucontrol from the funct table, then go to ALUWB.
  - ALUWB: regwrite=1, regdst=1, memtoreg=0, then go to FETCH.
  - BRANCH: alusrca=1, alusrcb=00, SUB, pcsrc=01, branch=1, then go to FETCH. pcen=zero.
  - ADDIEX: alusrca=1, alusrcb=10, ADD, then go to ADDIWB.
  - ADDIWB: regwrite=1, regdst=0, memtoreg=0, then go to FETCH.
  - JUMP: pcsrc=10, pcwrite=1, then go to FETCH.
- Funct table (R-type):
  - 100000 -> ADD
  - 100010 -> SUB
  - 100100 -> AND
  - 100101 -> OR
  - 101010 -> SLT
  - anything else -> ADD; illegal is not raised.
- Unencoded state values fall through to FETCH.
- Handshake: mem_req stays asserted and the address select stays stable until mem_ready. mem_ready outside a memory state is ignored.
- Instruction latency with zero memory wait:
  - lw: 5 cycles
  - sw, R-type, addi: 4 cycles
  - beq, j: 3 cycles
  - Each memory wait cycle adds 1.

Optional Feature:
- Macro MC_BNE_EN.
- Defined: op 000101 (bne) goes DECODE -> BRANCH. In BRANCH, branch_taken = ~zero for bne and zero for beq. Requires an internal 1-bit flag latched in DECODE.
- Undefined: op 000101 is illegal and goes to FETCH with illegal=1.

Decomposition:
- Package mc_pkg holds:
  - State encodings: FETCH=0 through JUMP=11.
  - Opcode constants.
  - Funct constants.
  - ALU codes: AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111.
- One sub-module, mc_aludec: a combinational funct/aluop-to-alucontrol decoder, instantiated once.

Test Plan:
- Reset low mid-MEMRD, then release: state=FETCH with regwrite=0 and memwrite=0 during reset; first post-reset cycle has mem_req=1, iord=0.
- lw (op 100011), mem_ready tied 1: visits FETCH, DECODE, MEMADR, MEMRD, MEMWB in 5 cycles; regwrite=1, memtoreg=1 only in cycle 5.
- sw with mem_ready held 0 for 3 cycles in MEMWR: memwrite=1 and mem_req=1 for 4 cycles, then FETCH.
- R-type funct 101010: alucontrol=0111 in EXECUTE; regdst=1, regwrite=1 in ALUWB.
- beq: zero=1 gives pcen=1, pcsrc=01 in BRANCH; zero=0 gives pcen=0. With MC_BNE_EN, op 000101 and zero=0 gives pcen=1.
- op 111111: illegal=1 for exactly one cycle in DECODE, returns to FETCH, no register or memory writes.
